// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one imem request at a time and
// delivers {pc, instr} to IF/ID through a registered valid/stall slot backed by a one-entry skid.
module fetch_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  if_valid_o,
    output logic [DATA_WIDTH-1:0] if_pc_o,
    output logic [DATA_WIDTH-1:0] if_instr_o
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pc_req_q, pc_req_d;
    logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic                  if_valid_q, if_valid_d;
    logic [DATA_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
    logic                  slot_free;
    logic                  in_flight;

    assign slot_free   = !if_valid_q || !stall_i;
    assign imem_req_o  = (state_q == S_FETCH) && !rst;
    assign imem_addr_o = pc_q;
    assign if_valid_o  = if_valid_q;
    assign if_pc_o     = if_pc_q;
    assign if_instr_o  = if_instr_q;

    // A response still owed by memory after this cycle; a same-cycle rvalid settles it.
    assign in_flight = ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid_i) ||
                       (state_q == S_FETCH && imem_gnt_i);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_req_d     = pc_req_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;

        if (if_valid_q && !stall_i) begin
            if_valid_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                if (imem_gnt_i) begin
                    pc_req_d = pc_q;
                    pc_d     = pc_q + DATA_WIDTH'(4);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (slot_free) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_req_q;
                        if_instr_d = imem_rdata_i;
                        state_d    = S_FETCH;
                    end else begin
                        skid_pc_d    = pc_req_q;
                        skid_instr_d = imem_rdata_i;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (slot_free) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = skid_pc_q;
                    if_instr_d = skid_instr_q;
                    state_d    = S_FETCH;
                end
            end
            default: begin
                if (imem_rvalid_i) begin
                    state_d = S_FETCH;
                end
            end
        endcase

        // Redirect overrides everything: slot and skid contents are wrong-path.
        if (redirect_i) begin
            pc_d       = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            if_valid_d = 1'b0;
            if_pc_d    = if_pc_q;
            if_instr_d = if_instr_q;
            state_d    = in_flight ? S_DRAIN : S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_req_q     <= pc_req_d;
        skid_pc_q    <= skid_pc_d;
        skid_instr_q <= skid_instr_d;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a memory responder and random stall/redirect/reset drive the
// DUT, while a monitor checks every consumed instruction against the expected program-order stream.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;

    logic        clk;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;

    fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int consumed = 0;
    logic [63:0] exp_q[$];

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Expected delivery after a restart: sequential words from base, wrapping at 2^32.
    task automatic restart_stream(input logic [31:0] base);
        logic [31:0] p;
        exp_q.delete();
        p = base;
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back({p, mem_f(p)});
            p = p + 32'd4;
        end
    endtask

    // Driver plus memory responder; inputs change 1 time unit after the rising edge.
    initial begin
        logic        outstanding;
        logic [31:0] out_addr;
        int          delay;
        logic        real_resp;
        logic        d_req;
        logic [31:0] d_addr;
        int          gnt_pct;
        rst = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        outstanding = 1'b0; out_addr = '0; delay = 0; real_resp = 1'b0;
        d_req = 1'b0; d_addr = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            if (rst) begin
                restart_stream(RST_PC);
                outstanding = 1'b0;
            end else begin
                if (redirect_i)
                    restart_stream({redirect_pc_i[31:2], 2'b00});
                if (imem_rvalid_i && real_resp)
                    outstanding = 1'b0;
                if (d_req && imem_gnt_i) begin
                    total++;
                    if (outstanding) begin
                        bad++;
                        $display("FAIL one_outstanding: second grant at addr %08h while %08h pending", d_addr, out_addr);
                    end
                    outstanding = 1'b1;
                    out_addr    = d_addr;
                    delay       = $urandom_range(0, 3);
                end
            end
            rst        = (cyc == 0) || (cyc == 2500);
            gnt_pct    = ((cyc / 150) % 2 == 1) ? 15 : 75;
            imem_gnt_i = !rst && ($urandom_range(0, 99) < gnt_pct);
            stall_i    = ($urandom_range(0, 99) < 30);
            redirect_i = !rst && ($urandom_range(0, 39) == 0);
            redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : 32'($urandom);
            if (!rst && outstanding && delay == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_f(out_addr);
                real_resp     = 1'b1;
            end else begin
                if (outstanding) delay--;
                imem_rvalid_i = !rst && !outstanding && ($urandom_range(0, 19) == 0);
                imem_rdata_i  = 32'($urandom);
                real_resp     = 1'b0;
            end
            #1;
            d_req  = imem_req_o;
            d_addr = imem_addr_o;
        end
        @(negedge clk);
        total++;
        if (consumed < 150) begin
            bad++;
            $display("FAIL throughput: consumed %0d instructions, required at least 150", consumed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Monitor: on the falling edge, inputs and outputs both describe the coming rising edge.
    initial begin
        logic        p_rst, p_hold, p_req, p_gnt, p_redir;
        logic [31:0] p_addr, p_pc, p_instr;
        logic [63:0] e;
        p_rst = 1'b0; p_hold = 1'b0; p_req = 1'b0; p_gnt = 1'b0; p_redir = 1'b0;
        p_addr = '0; p_pc = '0; p_instr = '0;
        forever begin
            @(negedge clk);
            if (p_rst) begin
                total++;
                if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0 || imem_req_o !== !rst) begin
                    bad++;
                    $display("FAIL reset_state: valid=%b pc=%08h instr=%08h req=%b, required 0/0/0/%b",
                             if_valid_o, if_pc_o, if_instr_o, imem_req_o, !rst);
                end
            end else if (p_redir) begin
                total++;
                if (if_valid_o !== 1'b0) begin
                    bad++;
                    $display("FAIL redirect_kill: if_valid=%b after redirect, required 0", if_valid_o);
                end
            end else if (p_hold) begin
                total++;
                if (if_valid_o !== 1'b1 || if_pc_o !== p_pc || if_instr_o !== p_instr) begin
                    bad++;
                    $display("FAIL stall_hold: valid=%b pc=%08h instr=%08h, required 1/%08h/%08h",
                             if_valid_o, if_pc_o, if_instr_o, p_pc, p_instr);
                end
            end
            if (p_req && !p_gnt && !p_redir && !p_rst && !rst) begin
                total++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== p_addr) begin
                    bad++;
                    $display("FAIL req_stable: req=%b addr=%08h, required 1/%08h", imem_req_o, imem_addr_o, p_addr);
                end
            end
            if (!rst && if_valid_o === 1'b1 && !stall_i) begin
                total++;
                consumed++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL deliver: got pc=%08h instr=%08h, no instruction expected", if_pc_o, if_instr_o);
                end else begin
                    e = exp_q.pop_front();
                    if (if_pc_o !== e[63:32] || if_instr_o !== e[31:0]) begin
                        bad++;
                        $display("FAIL deliver: got pc=%08h instr=%08h, required pc=%08h instr=%08h",
                                 if_pc_o, if_instr_o, e[63:32], e[31:0]);
                    end
                end
            end
            p_rst   = rst;
            p_redir = redirect_i && !rst;
            p_hold  = (if_valid_o === 1'b1) && stall_i && !redirect_i && !rst;
            p_req   = imem_req_o;
            p_gnt   = imem_gnt_i;
            p_addr  = imem_addr_o;
            p_pc    = if_pc_o;
            p_instr = if_instr_o;
        end
    end

endmodule
